// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator.
// Divides clk down to the pixel rate and walks x/y over the full frame
// (active + porches + sync). hsync/vsync/video_on are registered from the
// next-state counters, so they are always the decode of the x/y presented
// in the same cycle. frame_tick marks entry into vertical blank.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 2,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Counters are 10 bits wide; larger timings cannot be represented.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL/V_TOTAL must not exceed 1024");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]       V_BLANK  = 10'(V_ACTIVE);
    // Decode bounds kept at 11 bits so an active width of 1024 still works.
    localparam logic [10:0]      H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0]      V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0]      HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0]      HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0]      VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0]      VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_nxt, y_nxt;
    logic             hs_act, vs_act, von_nxt, ft_nxt;

    // Pixel strobe is a pure compare on the divider register.
    assign pixel_tick = (div == DIV_LAST);

    // Pixel-rate divider: counts 0..CLK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        if (reset || pixel_tick) div <= '0;
        else                     div <= div + 1'b1;
    end

    // Next raster position plus the output decode of that position.
    always_comb begin
        x_nxt = x;
        y_nxt = y;
        if (pixel_tick) begin
            if (x == H_LAST) begin
                x_nxt = '0;
                y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
            end else begin
                x_nxt = x + 1'b1;
            end
        end
        hs_act  = ({1'b0, x_nxt} >= HS_BEG) && ({1'b0, x_nxt} < HS_END);
        vs_act  = ({1'b0, y_nxt} >= VS_BEG) && ({1'b0, y_nxt} < VS_END);
        von_nxt = ({1'b0, x_nxt} < H_ACT) && ({1'b0, y_nxt} < V_ACT);
        // Only the edge that enters (0, V_ACTIVE) fires, so the pulse is one
        // clk wide even though the position is held for CLK_DIV clks.
        ft_nxt  = pixel_tick && (x_nxt == '0) && (y_nxt == V_BLANK);
    end

    // Raster registers; outputs update on the same edge as x/y.
    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            hsync      <= ~SYNC_POL;
            vsync      <= ~SYNC_POL;
            video_on   <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            x          <= x_nxt;
            y          <= y_nxt;
            hsync      <= hs_act ? SYNC_POL : ~SYNC_POL;
            vsync      <= vs_act ? SYNC_POL : ~SYNC_POL;
            video_on   <= von_nxt;
            frame_tick <= ft_nxt;
        end
    end

endmodule
